// File: rtl/core_pkg.sv
// Shared definitions for the RV32IC core: branch funct3 encodings and the
// redirect controller state type.
package core_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } br_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational RV32I branch condition evaluation from funct3 and the ALU
// compare flags (carry set means no borrow, i.e. a >= b unsigned).
module br_cond_eval
    import core_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       flag_s,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       flag_v,
    output logic       cond,
    output logic       reserved
);

    always_comb begin
        cond     = 1'b0;
        reserved = 1'b0;
        case (funct3)
            F3_BEQ:  cond = flag_z;
            F3_BNE:  cond = ~flag_z;
            F3_BLT:  cond = flag_s ^ flag_v;
            F3_BGE:  cond = ~(flag_s ^ flag_v);
            F3_BLTU: cond = ~flag_c;
            F3_BGEU: cond = flag_c;
            default: reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect sequencer: evaluates the branch condition, drives a PC
// redirect until fetch acks, then flushes IF/ID for a fixed number of cycles.
module branch_redirect_ctrl
    import core_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic             is_branch,
    input  logic             is_jump,
    input  logic [2:0]       funct3,
    input  logic             flag_s,
    input  logic             flag_z,
    input  logic             flag_c,
    input  logic             flag_v,
    input  logic [XLEN-1:0]  target,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_target,
    input  logic             redir_ack,
    output logic             flush,
    output logic             stall_ex,
    output logic             illegal_br,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [3:0]       FlushLoad = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    br_state_e  state;
    logic [3:0] flush_cnt;
    logic       cond;
    logic       reserved;
    logic       accept;
    logic       taken;

    br_cond_eval u_cond (
        .funct3   (funct3),
        .flag_s   (flag_s),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_v   (flag_v),
        .cond     (cond),
        .reserved (reserved)
    );

    assign br_ready = (state == IDLE);
    assign accept   = br_valid & br_ready;
    // Jumps override whatever the branch condition evaluates to.
    assign taken    = is_jump | (is_branch & cond);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            flush_cnt    <= 4'd0;
            redir_target <= '0;
            taken_cnt    <= '0;
            illegal_br   <= 1'b0;
            redir_valid  <= 1'b0;
            flush        <= 1'b0;
            stall_ex     <= 1'b0;
        end else begin
            illegal_br <= accept & is_branch & ~is_jump & reserved;
            unique case (state)
                IDLE: begin
                    if (accept && taken) begin
                        state        <= REDIRECT;
                        redir_target <= target;
                        taken_cnt    <= taken_cnt + CntOne;
                        redir_valid  <= 1'b1;
                        flush        <= 1'b1;
                        stall_ex     <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redir_ack) begin
                        state       <= FLUSH;
                        flush_cnt   <= FlushLoad;
                        redir_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state    <= IDLE;
                        flush    <= 1'b0;
                        stall_ex <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    redir_valid <= 1'b0;
                    flush       <= 1'b0;
                    stall_ex    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: driver pushes expectations from a
// compare-level reference model, a negedge monitor pops and checks.
module tb_branch_redirect_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned FC   = 2;
    localparam int unsigned CW   = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            br_valid, br_ready, is_branch, is_jump;
    logic [2:0]      funct3;
    logic            flag_s, flag_z, flag_c, flag_v;
    logic [XLEN-1:0] target, redir_target;
    logic            redir_valid, redir_ack, flush, stall_ex, illegal_br;
    logic [CW-1:0]   taken_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [XLEN-1:0] q_tgt[$];
    logic [CW-1:0]   q_cnt[$];
    int              q_flen[$];
    int              q_ill[$];
    logic [CW-1:0]   cnt_model;

    branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_valid     (br_valid),
        .br_ready     (br_ready),
        .is_branch    (is_branch),
        .is_jump      (is_jump),
        .funct3       (funct3),
        .flag_s       (flag_s),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_v       (flag_v),
        .target       (target),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .redir_ack    (redir_ack),
        .flush        (flush),
        .stall_ex     (stall_ex),
        .illegal_br   (illegal_br),
        .taken_cnt    (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: the branch outcome computed directly on the operands.
    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_flags(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] d;
        d      = {1'b0, a} - {1'b0, b};
        flag_z = (d[31:0] == 32'd0);
        flag_s = d[31];
        flag_c = ~d[32];
        flag_v = (a[31] != b[31]) && (d[31] != a[31]);
    endtask

    task automatic check_reset_vals();
        chk("rst_redir_valid", redir_valid, 0);
        chk("rst_redir_target", redir_target, 0);
        chk("rst_flush", flush, 0);
        chk("rst_stall_ex", stall_ex, 0);
        chk("rst_illegal_br", illegal_br, 0);
        chk("rst_taken_cnt", taken_cnt, 0);
        chk("rst_br_ready", br_ready, 1);
    endtask

    task automatic wait_idle();
        int w = 0;
        while (!br_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("idle_timeout", br_ready, 1);
    endtask

    task automatic do_req(input logic ib, input logic ij, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] tgt, input int ack_dly);
        logic tk;
        @(negedge clk);
        wait_idle();
        br_valid  = 1'b1;
        is_branch = ib;
        is_jump   = ij;
        funct3    = f3;
        target    = tgt;
        set_flags(a, b);
        redir_ack = 1'($urandom_range(0, 1));
        tk = ij || (ib && ref_cond(f3, a, b));
        @(posedge clk);
        if (tk) begin
            cnt_model++;
            q_tgt.push_back(tgt);
            q_cnt.push_back(cnt_model);
            q_flen.push_back(1 + ack_dly + int'(FC));
        end
        if (ib && !ij && (f3 == 3'd2 || f3 == 3'd3)) q_ill.push_back(1);
        @(negedge clk);
        br_valid = 1'b0;
        target   = $urandom;
        if (tk) begin
            for (int k = 0; k <= ack_dly; k++) begin
                redir_ack = (k == ack_dly);
                @(negedge clk);
            end
            redir_ack = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor
    logic            prev_rv, prev_fl;
    int              fl_len;
    logic [XLEN-1:0] held_tgt;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 1'b0;
            prev_fl = 1'b0;
            fl_len  = 0;
        end else begin
            chk("stall_eq_flush", stall_ex, flush);
            chk("ready_eq_not_stall", br_ready, !stall_ex);
            if (redir_valid && !prev_rv) begin
                if (q_tgt.size() == 0) chk("redir_unexpected", 0, 1);
                else begin
                    chk("redir_target", redir_target, q_tgt.pop_front());
                    chk("taken_cnt", taken_cnt, q_cnt.pop_front());
                end
                held_tgt = redir_target;
            end else if (redir_valid) begin
                chk("redir_target_stable", redir_target, held_tgt);
            end
            if (redir_valid) chk("flush_during_redir", flush, 1);
            if (flush) fl_len++;
            else if (prev_fl) begin
                if (q_flen.size() == 0) chk("flush_unexpected", 0, 1);
                else chk("flush_len", fl_len, q_flen.pop_front());
                fl_len = 0;
            end
            if (illegal_br) begin
                if (q_ill.size() == 0) chk("illegal_unexpected", 0, 1);
                else chk("illegal_br", 1, q_ill.pop_front());
            end
            prev_rv = redir_valid;
            prev_fl = flush;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        rst_n = 1'b0;
        br_valid = 0; is_branch = 0; is_jump = 0; funct3 = 0; target = 0; redir_ack = 0;
        flag_s = 0; flag_z = 0; flag_c = 0; flag_v = 0;
        cnt_model = '0;
        repeat (2) @(negedge clk);
        #1 check_reset_vals();
        #1 rst_n = 1'b1;

        do_req(1, 0, 3'd0, 32'd5, 32'd5, 32'h0000_0100, 0);          // BEQ taken
        do_req(1, 0, 3'd4, 32'hFFFF_FFFF, 32'd0, 32'h0000_0200, 1);  // BLT taken
        do_req(1, 0, 3'd7, 32'd1, 32'd2, 32'h0000_0300, 0);          // BGEU not taken
        @(negedge clk);
        chk("taken_cnt_after_not_taken", taken_cnt, cnt_model);
        do_req(1, 1, 3'd1, 32'd7, 32'd7, 32'h0000_0400, 0);          // jump priority
        do_req(1, 0, 3'd0, 32'd3, 32'd3, 32'h0000_0500, 5);          // long ack wait
        do_req(1, 0, 3'd2, 32'd0, 32'd0, 32'h0000_0600, 0);          // reserved
        do_req(1, 0, 3'd3, 32'd0, 32'd1, 32'h0000_0700, 0);          // reserved

        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = {1'b0, a[30:0]} ^ 32'h8000_0000;
            do_req(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   3'($urandom_range(0, 7)), a, b, $urandom, $urandom_range(0, 4));
        end

        // Reset asserted in the second flush cycle.
        @(negedge clk);
        wait_idle();
        br_valid = 1; is_jump = 1; is_branch = 0; target = 32'hDEAD_BEE0; redir_ack = 0;
        @(posedge clk);
        cnt_model++;
        q_tgt.push_back(32'hDEAD_BEE0);
        q_cnt.push_back(cnt_model);
        q_flen.push_back(1 + int'(FC));
        @(negedge clk);
        br_valid = 0; is_jump = 0; redir_ack = 1;
        @(negedge clk);
        redir_ack = 0;
        @(negedge clk);
        chk("in_flush_before_reset", flush, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        q_tgt.delete(); q_cnt.delete(); q_flen.delete(); q_ill.delete();
        cnt_model = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Counter wrap: 2^CW taken transfers from reset bring it back to zero.
        for (int i = 0; i < (1 << CW); i++)
            do_req(0, 1, 3'd0, 32'd0, 32'd1, $urandom, 0);
        @(negedge clk);
        wait_idle();
        chk("taken_cnt_wrapped", taken_cnt, 0);

        repeat (3) @(negedge clk);
        chk("pending_redirects", q_tgt.size(), 0);
        chk("pending_flushes", q_flen.size(), 0);
        chk("pending_illegal", q_ill.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencing controller for branch and jump resolution in the RV32IC core. It accepts one resolved control-transfer request per handshake from the execute stage and evaluates the RV32I branch condition from funct3 and the ALU flags (S, Z, C, V). For taken transfers it drives a PC redirect to fetch, holds it until fetch acknowledges, then asserts a pipeline flush for a fixed number of cycles. It sits between the EX-stage ALU flags and the IF-stage PC mux, and stalls EX while a redirect is in flight.

## Interface
Parameters:
- XLEN, 32, width of PC and target
- FLUSH_CYCLES, 2, flush cycles after redirect ack; legal range 1..15
- CNT_W, 16, width of taken-transfer counter

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- br_valid  input  1  EX presents a control-transfer request
- br_ready  output  1  controller can accept a request
- is_branch  input  1  conditional branch (B-type)
- is_jump  input  1  unconditional jump (JAL/JALR/C.J/C.JR)
- funct3  input  3  branch condition select
- flag_s, flag_z, flag_c, flag_v  input  1 each  ALU flags for the compare
- target  input  XLEN  resolved target address
- redir_valid  output  1  redirect request to fetch
- redir_target  output  XLEN  redirect PC; stable while redir_valid
- redir_ack  input  1  fetch has taken the redirect
- flush  output  1  squash IF/ID contents
- stall_ex  output  1  hold EX stage
- illegal_br  output  1  one-cycle pulse: branch with reserved funct3
- taken_cnt  output  CNT_W  count of accepted taken transfers

## Operation
- Condition by funct3: 000 EQ=Z; 001 NE=~Z; 100 LT=(S!=V); 101 GE=(S==V); 110 LTU=~C; 111 GEU=C; 010/011 reserved -> not taken, illegal_br pulses next cycle.
- Accept = br_valid & br_ready. Taken = is_jump | (is_branch & cond). is_jump has priority when both set. Neither set -> accepted, no action.
- States: IDLE, REDIRECT, FLUSH.
- IDLE: br_ready=1. Accept & taken -> latch target into redir_target, taken_cnt+1 (wraps modulo 2^CNT_W), go REDIRECT. Otherwise stay.
- REDIRECT: redir_valid=1, flush=1. On redir_ack -> load counter with FLUSH_CYCLES-1, go FLUSH. Without ack, hold indefinitely with target unchanged.
- FLUSH: flush=1. Counter==0 -> IDLE; else decrement.
- br_ready = (state==IDLE). stall_ex = (state!=IDLE). redir_valid = (state==REDIRECT).
- redir_ack outside REDIRECT is ignored.

## Timing
- Reset, asynchronous: state IDLE, redir_valid=0, redir_target=0, flush=0, stall_ex=0, illegal_br=0, taken_cnt=0, counter=0. br_ready=1 once reset deasserts.
- Taken accept at edge N -> redir_valid=1, flush=1, stall_ex=1 from cycle N+1.
- redir_ack high in cycle M (in REDIRECT) -> FLUSH for cycles M+1 .. M+FLUSH_CYCLES, then IDLE with br_ready=1 at M+FLUSH_CYCLES+1.
- Minimum taken-transfer occupancy, with ack in the first REDIRECT cycle: 1+FLUSH_CYCLES cycles of stall. Back-to-back requests are accepted only in IDLE.
- Not-taken accept: zero-cycle effect, br_ready stays 1, a new request can be accepted the next cycle.
- Reset asserted mid-REDIRECT/FLUSH: immediate return to reset values, latched target discarded.

## Structure
- Shared package core_pkg: funct3 constants (F3_BEQ..F3_BGEU) and the state enum (IDLE/REDIRECT/FLUSH, 2-bit).
- One sub-module: br_cond_eval, purely combinational (funct3, flags -> cond, reserved). FSM, counter and registers live in branch_redirect_ctrl.

## Test plan
- BEQ with Z=1, target 0x0000_0100, redir_ack in the first REDIRECT cycle, FLUSH_CYCLES=2 -> redir_valid for 1 cycle at 0x100, flush for 3 cycles, taken_cnt=1, br_ready returns after 3 cycles.
- BLT with S=1, V=0 taken, then BGEU with C=0 not taken -> first redirects; second produces no redir_valid or flush, and taken_cnt stays 1.
- JAL with is_branch=1, funct3=001, Z=1 -> taken (jump priority), redirect issued.
- redir_ack held low 5 cycles in REDIRECT -> redir_valid, flush and stall_ex stay 1 and redir_target stays constant; ack then leads to the normal FLUSH sequence.
- Branch with funct3=010 -> not taken, illegal_br pulses exactly 1 cycle, no redirect.
- rst_n asserted in the second FLUSH cycle -> all outputs at reset values immediately; taken_cnt wraps from 0xFFFF to 0 on the next taken transfer after it is preloaded by 65535 transfers.
